// File: rtl/tia_line_sequencer.sv
// Horizontal line scheduler: 57-count line counter, HSYNC/HBLANK decode, WSYNC RDY halt, HMOVE blank.
// Optional HMOVE extended blank is built only when TIA_HMOVE_BLANK_EN is defined.
module tia_line_sequencer (
    input  logic       clk,
    input  logic       r,
    input  logic       phi1,
    input  logic       phi2,
    input  logic       wsync,
    input  logic       hmove,
    output logic [5:0] hcount,
    output logic       hsync,
    output logic       hblank,
    output logic       rdy,
    output logic       line_start,
    output logic       hmove_active
);

    localparam int unsigned HC_W        = 6;
    localparam int unsigned LINE_COUNTS = 57;
    localparam int unsigned HSYNC_START = 4;
    localparam int unsigned HSYNC_END   = 8;
    localparam int unsigned HBLANK_END  = 17;
    localparam int unsigned HMOVE_EXTRA = 2;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } rdy_state_t;

    rdy_state_t      state_q, state_d;
    logic [HC_W-1:0] hcount_q, hcount_d;
    logic            hsync_q, hsync_d;
    logic            hblank_q, hblank_d;
    logic            line_start_q, line_start_d;
    logic            hmove_active_q, hmove_active_d;
    logic            hmove_pending_q, hmove_pending_d;
    logic            wrap_c;
    logic [HC_W-1:0] blank_end_c;

`ifndef TIA_HMOVE_BLANK_EN
    logic unused_hmove;
    assign unused_hmove = hmove;
`endif

    // Next-state: counter, decode, RDY FSM and HMOVE bookkeeping.
    always_comb begin
        state_d         = state_q;
        hcount_d        = hcount_q;
        hsync_d         = hsync_q;
        hblank_d        = hblank_q;
        line_start_d    = 1'b0;
        hmove_active_d  = hmove_active_q;
        hmove_pending_d = hmove_pending_q;

        wrap_c      = phi1 && (hcount_q == HC_W'(LINE_COUNTS - 1));
        blank_end_c = hmove_active_q ? HC_W'(HBLANK_END + HMOVE_EXTRA) : HC_W'(HBLANK_END);

        if (phi1) begin
            hcount_d     = wrap_c ? '0 : hcount_q + HC_W'(1);
            line_start_d = wrap_c;
        end else if (phi2) begin
            hsync_d  = (hcount_q >= HC_W'(HSYNC_START)) && (hcount_q < HC_W'(HSYNC_END));
            hblank_d = (hcount_q < blank_end_c);
        end

        // wsync beats a coincident wrap, so the CPU stays halted a full extra line.
        unique case (state_q)
            ST_RUN:  if (wsync) state_d = ST_HALT;
            ST_HALT: if (wrap_c && !wsync) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase

`ifdef TIA_HMOVE_BLANK_EN
        if (wrap_c) begin
            hmove_active_d  = hmove_pending_q;
            hmove_pending_d = hmove;
        end else begin
            hmove_pending_d = hmove_pending_q | hmove;
        end
`else
        hmove_active_d  = 1'b0;
        hmove_pending_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state_q         <= ST_RUN;
            hcount_q        <= '0;
            hsync_q         <= 1'b0;
            hblank_q        <= 1'b1;
            line_start_q    <= 1'b0;
            hmove_active_q  <= 1'b0;
            hmove_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            hcount_q        <= hcount_d;
            hsync_q         <= hsync_d;
            hblank_q        <= hblank_d;
            line_start_q    <= line_start_d;
            hmove_active_q  <= hmove_active_d;
            hmove_pending_q <= hmove_pending_d;
        end
    end

    assign hcount       = hcount_q;
    assign hsync        = hsync_q;
    assign hblank       = hblank_q;
    assign rdy          = (state_q == ST_RUN);
    assign line_start   = line_start_q;
    assign hmove_active = hmove_active_q;

endmodule

// File: tb/tb_tia_line_sequencer.sv
// Self-checking bench for tia_line_sequencer: directed vector table, corner-case sequences,
// and randomized traffic against a line-level reference model.
module tb_tia_line_sequencer;

`ifdef TIA_HMOVE_BLANK_EN
    localparam bit HM_EN = 1'b1;
`else
    localparam bit HM_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       r = 1'b0, phi1 = 1'b0, phi2 = 1'b0, wsync = 1'b0, hmove = 1'b0;
    logic [5:0] hcount;
    logic       hsync, hblank, rdy, line_start, hmove_active;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int m_hc = 0;
    bit m_hs = 0, m_hb = 1, m_rdy = 1, m_ls = 0, m_ha = 0, m_pend = 0;

    tia_line_sequencer dut (
        .clk(clk), .r(r), .phi1(phi1), .phi2(phi2), .wsync(wsync), .hmove(hmove),
        .hcount(hcount), .hsync(hsync), .hblank(hblank), .rdy(rdy),
        .line_start(line_start), .hmove_active(hmove_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       r, p1, p2, ws, hm;
        bit [5:0] hc;
        bit       hs, hb, rdy, ls, ha;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock of spec behaviour, computed from the line rules.
    task automatic model_step(input bit ir, input bit p1, input bit p2, input bit ws, input bit hm);
        bit wrap;
        int blank_end;
        wrap = p1 && (m_hc == 56);
        if (ir) begin
            m_hc = 0; m_hs = 0; m_hb = 1; m_rdy = 1; m_ls = 0; m_ha = 0; m_pend = 0;
            return;
        end
        blank_end = (m_ha ? 19 : 17);
        m_ls = wrap;
        if (p1) begin
            m_hc = (m_hc + 1) % 57;
        end else if (p2) begin
            m_hs = (m_hc >= 4) && (m_hc < 8);
            m_hb = (m_hc < blank_end);
        end
        if (ws) m_rdy = 0;
        else if (wrap) m_rdy = 1;
        if (HM_EN) begin
            if (wrap) begin
                m_ha = m_pend;
                m_pend = hm;
            end else begin
                m_pend = m_pend | hm;
            end
        end
    endtask

    task automatic drive(input bit ir, input bit p1, input bit p2, input bit ws, input bit hm);
        r = ir; phi1 = p1; phi2 = p2; wsync = ws; hmove = hm;
        @(posedge clk);
        #1;
        model_step(ir, p1, p2, ws, hm);
        vectors++;
        if (hcount !== 6'(m_hc) || hsync !== m_hs || hblank !== m_hb || rdy !== m_rdy ||
            line_start !== m_ls || hmove_active !== m_ha) begin
            miscompares++;
            $display("FAIL model: got hc=%0d hs=%b hb=%b rdy=%b ls=%b ha=%b expected hc=%0d hs=%b hb=%b rdy=%b ls=%b ha=%b t=%0t",
                     hcount, hsync, hblank, rdy, line_start, hmove_active,
                     m_hc, m_hs, m_hb, m_rdy, m_ls, m_ha, $time);
        end
        r = 0; phi1 = 0; phi2 = 0; wsync = 0; hmove = 0;
    endtask

    // Alternate phi1/phi2 until a phi1 lands on count k (returns right after that phi1).
    task automatic advance_to(input int k);
        bit done;
        done = 0;
        for (int i = 0; i < 200; i++) begin
            drive(0, 1, 0, 0, 0);
            if (m_hc == k) begin
                done = 1;
                break;
            end
            drive(0, 0, 1, 0, 0);
        end
        check("advance_bound", 8'(done), 8'd1);
    endtask

    vec_t tbl[11];
    int   ls_cnt;

    initial begin
        //        r  p1 p2 ws hm  hc  hs hb rdy ls ha
        tbl[0]  = '{1, 0, 0, 0, 0, 6'd0, 0, 1, 1, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 6'd1, 0, 1, 1, 0, 0};
        tbl[2]  = '{0, 0, 1, 0, 0, 6'd1, 0, 1, 1, 0, 0};
        tbl[3]  = '{0, 1, 0, 0, 0, 6'd2, 0, 1, 1, 0, 0};
        tbl[4]  = '{0, 1, 0, 0, 0, 6'd3, 0, 1, 1, 0, 0};
        tbl[5]  = '{0, 1, 0, 0, 0, 6'd4, 0, 1, 1, 0, 0};
        tbl[6]  = '{0, 0, 1, 0, 0, 6'd4, 1, 1, 1, 0, 0};
        tbl[7]  = '{0, 1, 1, 0, 0, 6'd5, 1, 1, 1, 0, 0};
        tbl[8]  = '{0, 0, 0, 1, 0, 6'd5, 1, 1, 0, 0, 0};
        tbl[9]  = '{0, 1, 0, 1, 0, 6'd6, 1, 1, 0, 0, 0};
        tbl[10] = '{1, 1, 1, 1, 1, 6'd0, 0, 1, 1, 0, 0};

        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].r, tbl[i].p1, tbl[i].p2, tbl[i].ws, tbl[i].hm);
            check($sformatf("tbl%0d_out", i),
                  {2'b00, hsync, hblank, rdy, line_start, hmove_active, 1'b0},
                  {2'b00, tbl[i].hs, tbl[i].hb, tbl[i].rdy, tbl[i].ls, tbl[i].ha, 1'b0});
            check($sformatf("tbl%0d_hc", i), 8'(hcount), 8'(tbl[i].hc));
        end

        // 57 phi1 pulses: one wrap, one line_start, rdy unaffected
        ls_cnt = 0;
        for (int i = 0; i < 57; i++) begin
            drive(0, 1, 0, 0, 0);
            if (line_start) ls_cnt++;
        end
        check("wrap_hc", 8'(hcount), 8'd0);
        check("wrap_ls_count", 8'(ls_cnt), 8'd1);
        check("wrap_rdy", 8'(rdy), 8'd1);

        // full-line decode sweep
        for (int k = 1; k < 57; k++) begin
            drive(0, 1, 0, 0, 0);
            drive(0, 0, 1, 0, 0);
            check($sformatf("sweep_hsync_%0d", k), 8'(hsync), 8'((k >= 4 && k < 8) ? 1 : 0));
            check($sformatf("sweep_hblank_%0d", k), 8'(hblank), 8'((k < 17) ? 1 : 0));
        end

        // wsync mid-line halts until the wrap
        advance_to(20);
        drive(0, 0, 0, 1, 0);
        check("wsync_halt", 8'(rdy), 8'd0);
        advance_to(0);
        check("wsync_release", {6'd0, rdy, line_start}, 8'b11);

        // wsync on the wrap edge wins, halt for a whole line
        advance_to(56);
        drive(0, 1, 0, 1, 0);
        check("wrapws_hc_ls", {hcount, line_start, rdy}, {6'd0, 1'b1, 1'b0});
        advance_to(30);
        check("wrapws_mid", 8'(rdy), 8'd0);
        advance_to(0);
        check("wrapws_release", {6'd0, rdy, line_start}, 8'b11);

        // HMOVE extended blank
        advance_to(30);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        advance_to(0);
        check("hmove_active_on", 8'(hmove_active), 8'(HM_EN));
        advance_to(17);
        drive(0, 0, 1, 0, 0);
        check("hmove_hb17", 8'(hblank), 8'(HM_EN));
        advance_to(18);
        drive(0, 0, 1, 0, 0);
        check("hmove_hb18", 8'(hblank), 8'(HM_EN));
        advance_to(19);
        drive(0, 0, 1, 0, 0);
        check("hmove_hb19", 8'(hblank), 8'd0);
        advance_to(0);
        check("hmove_active_off", 8'(hmove_active), 8'd0);
        advance_to(16);
        drive(0, 0, 1, 0, 0);
        check("after_hb16", 8'(hblank), 8'd1);
        advance_to(17);
        drive(0, 0, 1, 0, 0);
        check("after_hb17", 8'(hblank), 8'd0);

        // reset in HALT with pending hmove discards everything
        advance_to(35);
        drive(0, 0, 0, 1, 1);
        advance_to(40);
        drive(1, 1, 1, 1, 1);
        check("rst_outs", {hcount, hsync, hblank}, {6'd0, 1'b0, 1'b1});
        check("rst_ctl", {5'd0, rdy, line_start, hmove_active}, 8'b100);
        advance_to(0);
        check("rst_line_ha", 8'(hmove_active), 8'd0);
        advance_to(17);
        drive(0, 0, 1, 0, 0);
        check("rst_line_hb17", 8'(hblank), 8'd0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 999) < 3, $urandom_range(0, 99) < 45,
                  $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
